// File: rtl/sram_ecc_adapter_pkg.sv
// Shared types and SECDED helpers for the SRAM ECC adapter.
// Hsiao (39,32) code: every data column has weight 3, check columns are unit
// vectors, so any single-bit error gives an odd-weight syndrome and any
// double-bit error gives a nonzero even-weight syndrome.
package sram_ecc_adapter_pkg;

  localparam int DATA_W = 32;
  localparam int ECC_W  = 7;
  localparam int CODE_W = DATA_W + ECC_W;

  // Bit positions inside the two-bit error report
  localparam int ERR_CORR   = 0;
  localparam int ERR_UNCORR = 1;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RD_WAIT  = 2'd1,
    RMW_WAIT = 2'd2,
    RMW_WR   = 2'd3
  } state_e;

  // H-matrix column for data bit idx (the first 32 weight-3 patterns in ascending order)
  function automatic logic [ECC_W-1:0] h_col(input int idx);
    logic [ECC_W-1:0] col;
    case (idx)
      0:  col = 7'b0000111;
      1:  col = 7'b0001011;
      2:  col = 7'b0001101;
      3:  col = 7'b0001110;
      4:  col = 7'b0010011;
      5:  col = 7'b0010101;
      6:  col = 7'b0010110;
      7:  col = 7'b0011001;
      8:  col = 7'b0011010;
      9:  col = 7'b0011100;
      10: col = 7'b0100011;
      11: col = 7'b0100101;
      12: col = 7'b0100110;
      13: col = 7'b0101001;
      14: col = 7'b0101010;
      15: col = 7'b0101100;
      16: col = 7'b0110001;
      17: col = 7'b0110010;
      18: col = 7'b0110100;
      19: col = 7'b0111000;
      20: col = 7'b1000011;
      21: col = 7'b1000101;
      22: col = 7'b1000110;
      23: col = 7'b1001001;
      24: col = 7'b1001010;
      25: col = 7'b1001100;
      26: col = 7'b1010001;
      27: col = 7'b1010010;
      28: col = 7'b1010100;
      29: col = 7'b1011000;
      30: col = 7'b1100001;
      31: col = 7'b1100010;
      default: col = 7'b0000000;
    endcase
    return col;
  endfunction

  // Check byte: XOR of the columns of all set data bits
  function automatic logic [ECC_W-1:0] ecc_encode(input logic [DATA_W-1:0] data);
    logic [ECC_W-1:0] ecc;
    ecc = '0;
    for (int i = 0; i < DATA_W; i++) begin
      if (data[i]) ecc = ecc ^ h_col(i);
    end
    return ecc;
  endfunction

  // Syndrome of a stored codeword {ecc, data}; zero means clean
  function automatic logic [ECC_W-1:0] ecc_syndrome(input logic [CODE_W-1:0] code);
    return ecc_encode(code[DATA_W-1:0]) ^ code[CODE_W-1:DATA_W];
  endfunction

  // Replace the bytes of old_w whose enable is set with the bytes of wr_w
  function automatic logic [DATA_W-1:0] merge_bytes(input logic [DATA_W-1:0] old_w,
                                                    input logic [DATA_W-1:0] wr_w,
                                                    input logic [3:0]        be);
    logic [DATA_W-1:0] m;
    for (int b = 0; b < 4; b++) begin
      m[b*8 +: 8] = be[b] ? wr_w[b*8 +: 8] : old_w[b*8 +: 8];
    end
    return m;
  endfunction

  // Active-low per-bit write mask for the data field from byte enables
  function automatic logic [DATA_W-1:0] byte_wbeb(input logic [3:0] be);
    logic [DATA_W-1:0] m;
    for (int b = 0; b < 4; b++) begin
      m[b*8 +: 8] = {8{~be[b]}};
    end
    return m;
  endfunction

endpackage

// File: rtl/sram_secded_39_32_dec.sv
// Combinational SECDED (39,32) decoder: corrects single-bit errors, flags
// double-bit (and other non-column) syndromes as uncorrectable and then
// passes the raw data through. With ECC_EN=0 it is a plain pass-through.
module sram_secded_39_32_dec
  import sram_ecc_adapter_pkg::*;
#(
  parameter bit ECC_EN = 1'b1
) (
  input  logic [CODE_W-1:0] code_i,
  output logic [DATA_W-1:0] data_o,
  output logic [1:0]        err_o
);

  logic [ECC_W-1:0] syn;
  logic             hit;

  assign syn = ecc_syndrome(code_i);

  // Classify the syndrome and flip the matching data bit when it is a single error
  always_comb begin
    data_o = code_i[DATA_W-1:0];
    err_o  = 2'b00;
    hit    = 1'b0;
    if (ECC_EN && (syn != '0)) begin
      if (^syn) begin
        for (int i = 0; i < DATA_W; i++) begin
          if (syn == h_col(i)) begin
            data_o[i] = ~code_i[i];
            hit       = 1'b1;
          end
        end
        // A lone check-bit error leaves the data intact
        if ($countones(syn) == 1) hit = 1'b1;
      end
      if (hit) err_o[ERR_CORR]   = 1'b1;
      else     err_o[ERR_UNCORR] = 1'b1;
    end
  end

endmodule

// File: rtl/sram_ecc_adapter.sv
// Request-side front end for the 8192x39 bit-enable SRAM macro.
// Build option SRAM_ECC_EN: when defined, stores a (39,32) SECDED check byte,
// corrects reads and performs read-modify-write for partial writes; when
// undefined, writes use byte write masks directly and no check byte is kept.
module sram_ecc_adapter
  import sram_ecc_adapter_pkg::*;
#(
  parameter int          AW        = 13,
  parameter logic [10:0] SRAM_TRIM = 11'h0
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              req_i,
  output logic              gnt_o,
  input  logic              we_i,
  input  logic [AW-1:0]     addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [3:0]        be_i,
  output logic              rvalid_o,
  output logic [DATA_W-1:0] rdata_o,
  output logic [1:0]        rerror_o,
  output logic              sram_ren_o,
  output logic              sram_wen_o,
  output logic [AW-1:0]     sram_adr_o,
  output logic [CODE_W-1:0] sram_din_o,
  output logic [CODE_W-1:0] sram_wbeb_o,
  input  logic [CODE_W-1:0] sram_q_i,
  output logic [10:0]       sram_trim_o
);

`ifdef SRAM_ECC_EN
  localparam bit ECC_EN = 1'b1;
`else
  localparam bit ECC_EN = 1'b0;
`endif

  state_e            state_q;
  logic              rvalid_q;
  logic [DATA_W-1:0] rdata_q;
  logic [1:0]        rerror_q;

  logic              accept;
  logic              be_none;
  logic              rd_now;
  logic              wr_now;
  logic [DATA_W-1:0] dec_data;
  logic [1:0]        dec_err;

  assign gnt_o   = rst_ni && (state_q == IDLE);
  assign accept  = gnt_o && req_i;
  assign be_none = (be_i == 4'h0);

`ifdef SRAM_ECC_EN
  logic              be_full;
  logic [AW-1:0]     addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [3:0]        be_q;
  logic [DATA_W-1:0] merged_q;
  logic [1:0]        err_q;

  assign be_full = (be_i == 4'hF);
  // Reads and partial writes both start with a macro read
  assign rd_now  = accept && (!we_i || (!be_full && !be_none));
  assign wr_now  = accept && we_i && be_full;

  // Hold the partial-write request, then the merged word and its error status
  always_ff @(posedge clk_i) begin
    if (accept) begin
      addr_q  <= addr_i;
      wdata_q <= wdata_i;
      be_q    <= be_i;
    end
    if (state_q == RMW_WAIT) begin
      merged_q <= merge_bytes(dec_data, wdata_q, be_q);
      err_q    <= dec_err;
    end
  end
`else
  assign rd_now = accept && !we_i;
  assign wr_now = accept && we_i && !be_none;
`endif

  sram_secded_39_32_dec #(
    .ECC_EN (ECC_EN)
  ) u_dec (
    .code_i (sram_q_i),
    .data_o (dec_data),
    .err_o  (dec_err)
  );

  // Macro strobes: from the live request in IDLE, from the held merge in RMW_WR
  always_comb begin
    sram_ren_o = rd_now;
    sram_wen_o = wr_now;
    sram_adr_o = addr_i;
`ifdef SRAM_ECC_EN
    sram_din_o  = {ecc_encode(wdata_i), wdata_i};
    sram_wbeb_o = wr_now ? {CODE_W{1'b0}} : {CODE_W{1'b1}};
    if (rst_ni && (state_q == RMW_WR)) begin
      // An uncorrectable read leaves the stored word untouched
      sram_adr_o  = addr_q;
      sram_din_o  = {ecc_encode(merged_q), merged_q};
      sram_wen_o  = !err_q[ERR_UNCORR];
      sram_wbeb_o = err_q[ERR_UNCORR] ? {CODE_W{1'b1}} : {CODE_W{1'b0}};
    end
`else
    sram_din_o  = {{ECC_W{1'b0}}, wdata_i};
    sram_wbeb_o = wr_now ? {{ECC_W{1'b1}}, byte_wbeb(be_i)} : {CODE_W{1'b1}};
`endif
  end

  // Request FSM with registered response outputs
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      rerror_q <= '0;
    end else begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      rerror_q <= '0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            if (!we_i) begin
              state_q <= RD_WAIT;
`ifdef SRAM_ECC_EN
            end else if (be_full || be_none) begin
              rvalid_q <= 1'b1;
            end else begin
              state_q <= RMW_WAIT;
`else
            end else begin
              rvalid_q <= 1'b1;
`endif
            end
          end
        end
        RD_WAIT: begin
          rvalid_q <= 1'b1;
          rdata_q  <= dec_data;
          rerror_q <= dec_err;
          state_q  <= IDLE;
        end
        RMW_WAIT: begin
`ifdef SRAM_ECC_EN
          state_q <= RMW_WR;
`else
          state_q <= IDLE;
`endif
        end
        RMW_WR: begin
          rvalid_q <= 1'b1;
`ifdef SRAM_ECC_EN
          rerror_q <= err_q;
`endif
          state_q  <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rvalid_o    = rvalid_q;
  assign rdata_o     = rdata_q;
  assign rerror_o    = rerror_q;
  assign sram_trim_o = SRAM_TRIM;

endmodule

// File: tb/tb_sram_ecc_adapter.sv
// Scoreboard bench for sram_ecc_adapter with a behavioural bit-enable SRAM
// model and read-error injection. Expectations follow SRAM_ECC_EN.
module tb_sram_ecc_adapter;

`ifdef SRAM_ECC_EN
  localparam bit ECC = 1'b1;
`else
  localparam bit ECC = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_ni;
  logic        req_i;
  logic        gnt_o;
  logic        we_i;
  logic [12:0] addr_i;
  logic [31:0] wdata_i;
  logic [3:0]  be_i;
  logic        rvalid_o;
  logic [31:0] rdata_o;
  logic [1:0]  rerror_o;
  logic        sram_ren_o;
  logic        sram_wen_o;
  logic [12:0] sram_adr_o;
  logic [38:0] sram_din_o;
  logic [38:0] sram_wbeb_o;
  logic [38:0] sram_q_i;
  logic [10:0] sram_trim_o;

  logic [38:0] mem [8192] = '{default: '0};
  logic [38:0] q_r = '0;
  logic [38:0] inj_mask = '0;

  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;

  typedef struct {
    logic [31:0] data;
    logic [1:0]  err;
    int          cyc;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;

  always #5 clk = ~clk;

  sram_ecc_adapter dut (
    .clk_i       (clk),
    .rst_ni      (rst_ni),
    .req_i       (req_i),
    .gnt_o       (gnt_o),
    .we_i        (we_i),
    .addr_i      (addr_i),
    .wdata_i     (wdata_i),
    .be_i        (be_i),
    .rvalid_o    (rvalid_o),
    .rdata_o     (rdata_o),
    .rerror_o    (rerror_o),
    .sram_ren_o  (sram_ren_o),
    .sram_wen_o  (sram_wen_o),
    .sram_adr_o  (sram_adr_o),
    .sram_din_o  (sram_din_o),
    .sram_wbeb_o (sram_wbeb_o),
    .sram_q_i    (sram_q_i),
    .sram_trim_o (sram_trim_o)
  );

  always @(posedge clk) cyc <= cyc + 1;

  // SRAM macro: registered read with optional bit flips, bit-masked write
  always @(posedge clk) begin
    if (sram_ren_o === 1'b1) q_r <= mem[sram_adr_o] ^ inj_mask;
    if (sram_wen_o === 1'b1)
      mem[sram_adr_o] <= (mem[sram_adr_o] & sram_wbeb_o) | (sram_din_o & ~sram_wbeb_o);
  end
  assign sram_q_i = q_r;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Response monitor
  always @(negedge clk) begin
    if (rvalid_o === 1'b1) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_rvalid: got rvalid_o=1 at cycle %0d, expected no response", cyc);
      end else begin
        mon_e = sb.pop_front();
        chk("rdata", {32'h0, rdata_o}, {32'h0, mon_e.data});
        chk("rerror", {62'h0, rerror_o}, {62'h0, mon_e.err});
        chk("rvalid_cycle", 64'(cyc), 64'(mon_e.cyc));
      end
    end
  end

  // Present a request (called just after a rising edge); returns at the
  // falling edge of the cycle it is accepted in, with the request still driven
  task automatic issue(input logic we, input logic [12:0] a, input logic [31:0] d,
                       input logic [3:0] be, input logic [38:0] mask, input bit push,
                       input logic [31:0] ed, input logic [1:0] ee, input int lat);
    int   waited;
    exp_t e;
    waited   = 0;
    req_i    = 1'b1;
    we_i     = we;
    addr_i   = a;
    wdata_i  = d;
    be_i     = be;
    inj_mask = mask;
    @(negedge clk);
    while (gnt_o !== 1'b1 && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    n_checks++;
    if (gnt_o !== 1'b1) begin
      n_fail++;
      $display("FAIL gnt_timeout: got gnt_o=%b after %0d cycles, expected 1", gnt_o, waited);
    end else if (push) begin
      e.data = ed;
      e.err  = ee;
      e.cyc  = cyc + lat;
      sb.push_back(e);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    req_i    = 1'b0;
    we_i     = 1'b0;
    inj_mask = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  initial begin
    int w;
    rst_ni   = 1'b0;
    req_i    = 1'b1;
    we_i     = 1'b1;
    addr_i   = 13'h1A5;
    wdata_i  = 32'hFFFFFFFF;
    be_i     = 4'hF;

    // Reset held with a live write request
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("rst_gnt", 64'(gnt_o), 64'h0);
      chk("rst_ren", 64'(sram_ren_o), 64'h0);
      chk("rst_wen", 64'(sram_wen_o), 64'h0);
      chk("rst_wbeb", 64'(sram_wbeb_o), 64'h7F_FFFF_FFFF);
      chk("rst_rvalid", 64'(rvalid_o), 64'h0);
      @(posedge clk); #1;
    end
    rst_ni = 1'b1;
    req_i  = 1'b0;
    we_i   = 1'b0;
    chk("trim", 64'(sram_trim_o), 64'h0);

    // Full write then read
    issue(1'b1, 13'h1A5, 32'hDEADBEEF, 4'hF, '0, 1'b1, 32'h0, 2'b00, 1);
    chk("fw_wen", 64'(sram_wen_o), 64'h1);
    chk("fw_ren", 64'(sram_ren_o), 64'h0);
    chk("fw_adr", 64'(sram_adr_o), 64'h1A5);
    chk("fw_din_data", 64'(sram_din_o[31:0]), 64'hDEADBEEF);
    chk("fw_wbeb", 64'(sram_wbeb_o), ECC ? 64'h0 : 64'h7F_0000_0000);
    step();
    issue(1'b0, 13'h1A5, 32'h0, 4'hF, '0, 1'b1, 32'hDEADBEEF, 2'b00, 2);
    chk("rd_ren", 64'(sram_ren_o), 64'h1);
    chk("rd_wen", 64'(sram_wen_o), 64'h0);
    step();

    // Check byte of single-bit data words
    issue(1'b1, 13'h002, 32'h00000001, 4'hF, '0, 1'b1, 32'h0, 2'b00, 1);
    chk("enc_bit0", 64'(sram_din_o), ECC ? 64'h07_0000_0001 : 64'h00_0000_0001);
    step();
    issue(1'b1, 13'h003, 32'h80000000, 4'hF, '0, 1'b1, 32'h0, 2'b00, 1);
    chk("enc_bit31", 64'(sram_din_o), ECC ? 64'h62_8000_0000 : 64'h00_8000_0000);
    step();
    issue(1'b0, 13'h002, 32'h0, 4'hF, '0, 1'b1, 32'h00000001, 2'b00, 2);
    step();
    issue(1'b0, 13'h003, 32'h0, 4'hF, '0, 1'b1, 32'h80000000, 2'b00, 2);
    step();

    // Partial write over 11223344
    issue(1'b1, 13'h0F0, 32'h11223344, 4'hF, '0, 1'b1, 32'h0, 2'b00, 1);
    step();
    issue(1'b1, 13'h0F0, 32'hAABBCCDD, 4'b0101, '0, 1'b1, 32'h0, 2'b00, ECC ? 3 : 1);
`ifdef SRAM_ECC_EN
    chk("pw_ren", 64'(sram_ren_o), 64'h1);
    chk("pw_wen_t0", 64'(sram_wen_o), 64'h0);
    step();
    chk("pw_wen_t1", 64'(sram_wen_o), 64'h0);
    chk("pw_gnt_t1", 64'(gnt_o), 64'h0);
    step();
    chk("pw_wen_t2", 64'(sram_wen_o), 64'h1);
    chk("pw_adr_t2", 64'(sram_adr_o), 64'h0F0);
    chk("pw_wbeb_t2", 64'(sram_wbeb_o), 64'h0);
    chk("pw_din_t2", 64'(sram_din_o[31:0]), 64'h11BB33DD);
    step();
`else
    chk("pw_wen", 64'(sram_wen_o), 64'h1);
    chk("pw_ren", 64'(sram_ren_o), 64'h0);
    chk("pw_wbeb", 64'(sram_wbeb_o), 64'h7F_FF00_FF00);
    chk("pw_din", 64'(sram_din_o[31:0]), 64'hAABBCCDD);
    step();
`endif
    issue(1'b0, 13'h0F0, 32'h0, 4'hF, '0, 1'b1, 32'h11BB33DD, 2'b00, 2);
    step();

    // Write with no byte enables: no macro access
    issue(1'b1, 13'h0F0, 32'hFFFFFFFF, 4'h0, '0, 1'b1, 32'h0, 2'b00, 1);
    chk("be0_ren", 64'(sram_ren_o), 64'h0);
    chk("be0_wen", 64'(sram_wen_o), 64'h0);
    step();
    issue(1'b0, 13'h0F0, 32'h0, 4'hF, '0, 1'b1, 32'h11BB33DD, 2'b00, 2);
    step();

    // Read error injection on a zero word and on DEADBEEF
    issue(1'b1, 13'h055, 32'h0, 4'hF, '0, 1'b1, 32'h0, 2'b00, 1);
    step();
    issue(1'b0, 13'h055, 32'h0, 4'hF, 39'h80, 1'b1, ECC ? 32'h0 : 32'h80, ECC ? 2'b01 : 2'b00, 2);
    step();
    issue(1'b0, 13'h055, 32'h0, 4'hF, 39'h100008, 1'b1, 32'h00100008, ECC ? 2'b10 : 2'b00, 2);
    step();
    issue(1'b0, 13'h055, 32'h0, 4'hF, 39'h08_0000_0000, 1'b1, 32'h0, ECC ? 2'b01 : 2'b00, 2);
    step();
    issue(1'b0, 13'h1A5, 32'h0, 4'hF, 39'h00_8000_0000, 1'b1,
          ECC ? 32'hDEADBEEF : 32'h5EADBEEF, ECC ? 2'b01 : 2'b00, 2);
    step();

    // Partial write whose read sees a double-bit error
    issue(1'b1, 13'h0F0, 32'h12345678, 4'b0011, 39'h100008, 1'b1, 32'h0,
          ECC ? 2'b10 : 2'b00, ECC ? 3 : 1);
`ifdef SRAM_ECC_EN
    chk("ue_ren", 64'(sram_ren_o), 64'h1);
    step();
    step();
    chk("ue_wen_skip", 64'(sram_wen_o), 64'h0);
    chk("ue_wbeb_skip", 64'(sram_wbeb_o), 64'h7F_FFFF_FFFF);
    step();
`else
    chk("ue_wen", 64'(sram_wen_o), 64'h1);
    step();
`endif
    issue(1'b0, 13'h0F0, 32'h0, 4'hF, '0, 1'b1, ECC ? 32'h11BB33DD : 32'h11BB5678, 2'b00, 2);
    step();

    // Partial write whose read sees a single-bit error: corrected merge is written
    issue(1'b1, 13'h1A5, 32'h55000000, 4'b1000, 39'h1, 1'b1, 32'h0,
          ECC ? 2'b01 : 2'b00, ECC ? 3 : 1);
`ifdef SRAM_ECC_EN
    step();
    step();
    chk("scrub_wen", 64'(sram_wen_o), 64'h1);
    chk("scrub_din", 64'(sram_din_o[31:0]), 64'h55ADBEEF);
    step();
`else
    step();
`endif
    issue(1'b0, 13'h1A5, 32'h0, 4'hF, '0, 1'b1, 32'h55ADBEEF, 2'b00, 2);
    step();

    // Reset while an access is in flight: response dropped, no write
`ifdef SRAM_ECC_EN
    issue(1'b1, 13'h0F0, 32'h000000EE, 4'b0001, '0, 1'b0, 32'h0, 2'b00, 3);
`else
    issue(1'b0, 13'h0F0, 32'h0, 4'hF, '0, 1'b0, 32'h0, 2'b00, 2);
`endif
    chk("mid_ren", 64'(sram_ren_o), 64'h1);
    step();
    rst_ni = 1'b0;
    @(negedge clk);
    chk("mid_rst_wen", 64'(sram_wen_o), 64'h0);
    chk("mid_rst_ren", 64'(sram_ren_o), 64'h0);
    chk("mid_rst_gnt", 64'(gnt_o), 64'h0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("mid_rst_wen2", 64'(sram_wen_o), 64'h0);
    chk("mid_rst_rvalid", 64'(rvalid_o), 64'h0);
    @(posedge clk); #1;
    rst_ni = 1'b1;
    @(negedge clk);
    chk("post_rst_gnt", 64'(gnt_o), 64'h1);
    @(posedge clk); #1;
    issue(1'b0, 13'h0F0, 32'h0, 4'hF, '0, 1'b1, ECC ? 32'h11BB33DD : 32'h11BB5678, 2'b00, 2);
    step();

    // Drain outstanding responses and watch for strays
    w = 0;
    while (sb.size() != 0 && w < 20) begin
      @(negedge clk);
      w++;
    end
    repeat (3) @(negedge clk);
    chk("sb_empty", 64'(sb.size()), 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
